// File: rtl/tb_output_checker_if.sv
// Stimulus/DUT-result bundle plus status outputs of the receive-side result checker.
interface tb_output_checker_if #(
    parameter int unsigned WIDTH      = 16,
    parameter int unsigned FIFO_DEPTH = 16,
    parameter int unsigned CNT_W      = 16
);
    localparam int unsigned PW = $clog2(FIFO_DEPTH) + 1;

    logic             i_exp_valid;
    logic [WIDTH-1:0] i_exp_data;
    logic             i_dut_valid;
    logic [WIDTH-1:0] i_dut_data;
    logic [WIDTH-1:0] i_mask;

    logic [CNT_W-1:0] o_checked_count;
    logic [CNT_W-1:0] o_error_count;
    logic [PW-1:0]    o_pending;
    logic             o_overflow;
    logic             o_underflow;
    logic             o_timeout;
    logic             o_test_complete;
    logic             o_test_fail;

    modport master (
        output i_exp_valid, i_exp_data, i_dut_valid, i_dut_data, i_mask,
        input  o_checked_count, o_error_count, o_pending, o_overflow,
               o_underflow, o_timeout, o_test_complete, o_test_fail
    );

    modport slave (
        input  i_exp_valid, i_exp_data, i_dut_valid, i_dut_data, i_mask,
        output o_checked_count, o_error_count, o_pending, o_overflow,
               o_underflow, o_timeout, o_test_complete, o_test_fail
    );
endinterface

// File: rtl/tb_output_checker.sv
// Receive-side checker: expected words queue in a FIFO, each DUT result pops one and
// is compared (masked) one cycle later; tracks errors, protocol faults and timeout.
module tb_output_checker #(
    parameter int unsigned WIDTH       = 16,
    parameter int unsigned FIFO_DEPTH  = 16,
    parameter int unsigned NUM_RESULTS = 64,
    parameter int unsigned TIMEOUT     = 1024,
    parameter int unsigned CNT_W       = 16
) (
    input  logic               i_clk,
    input  logic               i_reset_n,
    tb_output_checker_if.slave bus
);
    localparam int unsigned AW = $clog2(FIFO_DEPTH);
    localparam int unsigned PW = AW + 1;
    localparam int unsigned TW = $clog2(TIMEOUT + 1);

    typedef enum logic [1:0] {IDLE, RUN, DONE, TOUT} state_e;

    state_e           state_q;
    logic [WIDTH-1:0] mem_q [FIFO_DEPTH];
    logic [PW-1:0]    wr_q, rd_q, wr_d, rd_d, pending_q;
    logic             cmp_q;
    logic [WIDTH-1:0] cmp_exp_q, cmp_dut_q, cmp_mask_q;
    logic [CNT_W-1:0] checked_q, checked_d, errors_q, errors_d;
    logic [TW-1:0]    tmo_q, tmo_d;
    logic             ovf_q, unf_q, tout_q;
    logic             active, empty, full, push, pop, mismatch, last_cmp;

    always_comb begin
        active   = (state_q == IDLE) || (state_q == RUN);
        empty    = (wr_q == rd_q);
        full     = (wr_q[AW] != rd_q[AW]) && (wr_q[AW-1:0] == rd_q[AW-1:0]);
        pop      = active && bus.i_dut_valid && !empty;
        push     = active && bus.i_exp_valid && (!full || pop);
        wr_d     = wr_q + PW'(push);
        rd_d     = rd_q + PW'(pop);
        mismatch = |((cmp_exp_q ^ cmp_dut_q) & cmp_mask_q);

        checked_d = checked_q;
        errors_d  = errors_q;
        if (cmp_q && (checked_q != '1))
            checked_d = checked_q + CNT_W'(1);
        if (cmp_q && mismatch && (errors_q != '1))
            errors_d = errors_q + CNT_W'(1);
        last_cmp = (checked_d != checked_q) && (checked_d == CNT_W'(NUM_RESULTS));

        // Any input activity restarts the idle window, so the timeout lands exactly
        // TIMEOUT cycles after the last push or DUT valid.
        tmo_d = tmo_q;
        if (bus.i_dut_valid || bus.i_exp_valid || (pending_q == '0))
            tmo_d = '0;
        else if (state_q == RUN)
            tmo_d = tmo_q + TW'(1);
    end

    always_ff @(posedge i_clk) begin
        if (push)
            mem_q[wr_q[AW-1:0]] <= bus.i_exp_data;
    end

    always_ff @(posedge i_clk) begin
        if (!i_reset_n) begin
            state_q    <= IDLE;
            wr_q       <= '0;
            rd_q       <= '0;
            pending_q  <= '0;
            cmp_q      <= 1'b0;
            cmp_exp_q  <= '0;
            cmp_dut_q  <= '0;
            cmp_mask_q <= '0;
            checked_q  <= '0;
            errors_q   <= '0;
            tmo_q      <= '0;
            ovf_q      <= 1'b0;
            unf_q      <= 1'b0;
            tout_q     <= 1'b0;
        end else if (active) begin
            wr_q      <= wr_d;
            rd_q      <= rd_d;
            pending_q <= wr_d - rd_d;
            cmp_q     <= pop;
            if (pop) begin
                cmp_exp_q  <= mem_q[rd_q[AW-1:0]];
                cmp_dut_q  <= bus.i_dut_data;
                cmp_mask_q <= bus.i_mask;
            end
            checked_q <= checked_d;
            errors_q  <= errors_d;
            tmo_q     <= tmo_d;
            if (bus.i_exp_valid && full && !pop)
                ovf_q <= 1'b1;
            if (bus.i_dut_valid && empty)
                unf_q <= 1'b1;

            case (state_q)
                IDLE: begin
                    if (push)
                        state_q <= RUN;
                end
                RUN: begin
                    if (last_cmp) begin
                        state_q <= DONE;
                    end else if (tmo_d == TW'(TIMEOUT)) begin
                        state_q <= TOUT;
                        tout_q  <= 1'b1;
                    end
                end
                default: state_q <= state_q;
            endcase
        end
    end

    assign bus.o_checked_count = checked_q;
    assign bus.o_error_count   = errors_q;
    assign bus.o_pending       = pending_q;
    assign bus.o_overflow      = ovf_q;
    assign bus.o_underflow     = unf_q;
    assign bus.o_timeout       = tout_q;
    assign bus.o_test_complete = (state_q == DONE) || (state_q == TOUT);
    assign bus.o_test_fail     = (errors_q != '0) || ovf_q || unf_q || tout_q;
endmodule
